hdd_sd_bridge: RTL

Sector-transfer controller between the IIgs core's hard-drive port (`HDD_SECTOR`, `HDD_READ`, `HDD_WRITE`) and virtual-disk slot 0 of the HPS SD block-transfer interface. It latches single-cycle read/write requests from the core and drives the `sd_rd`/`sd_wr`/`sd_ack` handshake. It stalls the CPU through `cpu_wait` for the whole transfer and tracks image mount and read-only status. It adds write-protect rejection, read-over-write priority and a watchdog timeout with a sticky error flag.

---
 rtl/hdd_sd_bridge.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hdd_sd_bridge.sv
// Sector-transfer bridge between the IIgs hard-drive port and HPS SD slot 0.
// Latches read/write pulses, runs the sd_rd/sd_wr/sd_ack handshake and stalls the CPU meanwhile.
module hdd_sd_bridge #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_318_180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] hdd_sector,
   input  logic        hdd_read,
   input  logic        hdd_write,
   input  logic        img_mounted,
   input  logic        img_readonly,
   input  logic [63:0] img_size,
   input  logic        sd_ack,
   input  logic        sd_buff_wr,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        buff_we,
   output logic        cpu_wait,
   output logic        hdd_mounted,
   output logic        hdd_protect,
   output logic        hdd_error
);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   state_t      state, state_nx;
   logic        rd_pend, wr_pend, rd_pend_nx, wr_pend_nx;
   logic [15:0] rd_sec, wr_sec, rd_sec_nx, wr_sec_nx;
   logic        svc_wr, svc_nx;
   logic        old_ack;
   logic [23:0] cnt, cnt_nx;
   logic [31:0] lba_nx;
   logic        rd_nx, wr_nx, wait_nx, err_nx;
   logic        rej_rd, rej_wr, done, abort;
   logic        ack_rise, ack_fall, expired;

   // Mount status survives reset, so it lives in its own unreset register.
   logic        mounted_q = 1'b0;
   logic        protect_q = 1'b0;

   always_ff @(posedge clk) begin
      if (img_mounted) begin
         mounted_q <= (img_size != 64'd0);
         protect_q <= img_readonly;
      end
   end

   assign hdd_mounted = mounted_q;
   assign hdd_protect = protect_q;
   assign buff_we     = sd_buff_wr & sd_ack;

   assign ack_rise = sd_ack & ~old_ack;
   assign ack_fall = ~sd_ack & old_ack;
   assign expired  = (cnt == TIMEOUT_CYCLES - 24'd1);

   always_comb begin
      state_nx = state;
      rd_nx    = sd_rd;
      wr_nx    = sd_wr;
      wait_nx  = cpu_wait;
      err_nx   = hdd_error;
      lba_nx   = sd_lba;
      svc_nx   = svc_wr;
      cnt_nx   = (state == IDLE) ? cnt : cnt + 24'd1;
      rej_rd   = 1'b0;
      rej_wr   = 1'b0;
      done     = 1'b0;
      abort    = 1'b0;

      case (state)
         IDLE: begin
            // Read always wins; a competing write simply stays pending.
            if (rd_pend || hdd_read) begin
               if (!mounted_q) begin
                  rej_rd = 1'b1;
                  err_nx = 1'b1;
               end else begin
                  lba_nx   = {16'd0, hdd_read ? hdd_sector : rd_sec};
                  rd_nx    = 1'b1;
                  svc_nx   = 1'b0;
                  wait_nx  = 1'b1;
                  err_nx   = 1'b0;
                  cnt_nx   = 24'd0;
                  state_nx = REQ;
               end
            end else if (wr_pend || hdd_write) begin
               if (!mounted_q || protect_q) begin
                  rej_wr = 1'b1;
                  err_nx = 1'b1;
               end else begin
                  lba_nx   = {16'd0, hdd_write ? hdd_sector : wr_sec};
                  wr_nx    = 1'b1;
                  svc_nx   = 1'b1;
                  wait_nx  = 1'b1;
                  err_nx   = 1'b0;
                  cnt_nx   = 24'd0;
                  state_nx = REQ;
               end
            end
         end
         REQ: begin
            if (ack_rise) begin
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
               cnt_nx   = 24'd0;
               state_nx = XFER;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         XFER: begin
            if (ack_fall) begin
               done     = 1'b1;
               wait_nx  = 1'b0;
               state_nx = IDLE;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (abort) begin
         rd_nx    = 1'b0;
         wr_nx    = 1'b0;
         wait_nx  = 1'b0;
         err_nx   = 1'b1;
         done     = 1'b1;
         state_nx = IDLE;
      end

      // A fresh pulse beats completion-clear, but a rejection discards it.
      rd_pend_nx = (hdd_read  | (rd_pend & ~(done & ~svc_wr))) & ~rej_rd;
      wr_pend_nx = (hdd_write | (wr_pend & ~(done &  svc_wr))) & ~rej_wr;
      rd_sec_nx  = hdd_read  ? hdd_sector : rd_sec;
      wr_sec_nx  = hdd_write ? hdd_sector : wr_sec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rd_pend   <= 1'b0;
         wr_pend   <= 1'b0;
         rd_sec    <= 16'd0;
         wr_sec    <= 16'd0;
         svc_wr    <= 1'b0;
         old_ack   <= 1'b0;
         cnt       <= 24'd0;
         sd_lba    <= 32'd0;
         sd_rd     <= 1'b0;
         sd_wr     <= 1'b0;
         cpu_wait  <= 1'b0;
         hdd_error <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_pend   <= rd_pend_nx;
         wr_pend   <= wr_pend_nx;
         rd_sec    <= rd_sec_nx;
         wr_sec    <= wr_sec_nx;
         svc_wr    <= svc_nx;
         old_ack   <= sd_ack;
         cnt       <= cnt_nx;
         sd_lba    <= lba_nx;
         sd_rd     <= rd_nx;
         sd_wr     <= wr_nx;
         cpu_wait  <= wait_nx;
         hdd_error <= err_nx;
      end
   end

endmodule
